// File: rtl/uart_bist_ctrl.sv
// UART loopback self-test: sends an LFSR byte sequence through the UART and compares the echoes.
// Optional build macro UART_BIST_STOP_ON_FAIL_EN ends a run at the first bad byte.
module uart_bist_ctrl #(
    parameter int unsigned CLK_FREQ  = 66000000,
    parameter int unsigned BAUD      = 9600,
    parameter int unsigned NUM_BYTES = 4,
    parameter logic [7:0]  SEED      = 8'hA5,
    parameter int unsigned TIMEOUT   = (CLK_FREQ / BAUD) * 12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       tx_busy,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic [7:0] tx_data,
    output logic       tx_load,
    output logic       sel,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       m_i_faulty,
    output logic [7:0] err_count
);
    // An all-zero seed would lock the LFSR at zero.
    localparam logic [7:0]  SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam int unsigned TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
    localparam logic [7:0]  LAST_IDX = 8'(NUM_BYTES - 1);

    typedef enum logic [2:0] {IDLE, SETUP, LOAD, WAIT_RX, CHECK, DONE} state_e;

    state_e        state_q, state_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    err_q, err_d;
    logic [7:0]    rx_q, rx_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          to_q, to_d;
    logic          byte_bad;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            lfsr_q  <= SEED_EFF;
            cnt_q   <= '0;
            err_q   <= '0;
            rx_q    <= '0;
            tmr_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            rx_q    <= rx_d;
            tmr_q   <= tmr_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rx_d     = rx_q;
        tmr_d    = tmr_q;
        to_d     = to_q;
        byte_bad = to_q || (rx_q != lfsr_q);
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start) state_d = SETUP;
                SETUP: begin
                    lfsr_d  = SEED_EFF;
                    cnt_d   = '0;
                    err_d   = '0;
                    state_d = LOAD;
                end
                LOAD: if (!tx_busy) begin
                    tmr_d   = '0;
                    to_d    = 1'b0;
                    state_d = WAIT_RX;
                end
                WAIT_RX: begin
                    tmr_d = tmr_q + 1'b1;
                    // A byte arriving on the final timer cycle still counts as received.
                    if (rx_valid) begin
                        rx_d    = rx_data;
                        to_d    = 1'b0;
                        state_d = CHECK;
                    end else if (tmr_q == TMR_LAST) begin
                        to_d    = 1'b1;
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    if (byte_bad) err_d = sat_inc(err_q);
                    lfsr_d = lfsr_next(lfsr_q);
                    cnt_d  = cnt_q + 8'd1;
`ifdef UART_BIST_STOP_ON_FAIL_EN
                    state_d = (cnt_q == LAST_IDX || byte_bad) ? DONE : LOAD;
`else
                    state_d = (cnt_q == LAST_IDX) ? DONE : LOAD;
`endif
                end
                DONE: if (start) state_d = SETUP;
                default: state_d = IDLE;
            endcase
        end
    end

    assign tx_load    = (state_q == LOAD) && !tx_busy;
    assign busy       = (state_q == SETUP) || (state_q == LOAD) ||
                        (state_q == WAIT_RX) || (state_q == CHECK);
    assign sel        = busy;
    assign done       = (state_q == DONE);
    assign pass       = done && (err_q == 8'd0);
    assign m_i_faulty = done && (err_q != 8'd0);
    assign err_count  = err_q;
    assign tx_data    = ((state_q == LOAD) || (state_q == WAIT_RX) || (state_q == CHECK))
                        ? lfsr_q : 8'h00;
endmodule

// File: tb/tb_uart_bist_ctrl.sv
// Bench for uart_bist_ctrl: a loopback echo model plus table-driven, hand-written and random runs.
`timescale 1ns/1ps
module tb_uart_bist_ctrl;
    localparam int T  = 120;
    localparam int NB = 4;
`ifdef UART_BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst, start, abort, tx_busy;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] tx_data, err_count;
    logic       tx_load, sel, busy, done, pass, m_i_faulty;

    always #5 clk = ~clk;

    uart_bist_ctrl #(.NUM_BYTES(NB), .SEED(8'hA5), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .tx_busy(tx_busy),
        .rx_valid(rx_valid), .rx_data(rx_data), .tx_data(tx_data), .tx_load(tx_load),
        .sel(sel), .busy(busy), .done(done), .pass(pass), .m_i_faulty(m_i_faulty),
        .err_count(err_count)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Loopback model: each load is echoed (optionally corrupted) a configured number of cycles later.
    int               cyc = 0;
    int               load_cnt = 0;
    int               load_cyc[$];
    logic [7:0]       load_dat[$];
    int               busy_viol = 0;
    bit               pend = 0;
    int               due = 0;
    logic [7:0]       pdat = 8'h00;
    logic [3:0][15:0] cfg_dly = '0;
    logic [3:0][7:0]  cfg_msk = '0;
    int               base = 0;

    always @(negedge clk) begin
        int k;
        #2;
        cyc++;
        rx_valid = 1'b0;
        if (pend && cyc == due) begin
            rx_valid = 1'b1;
            rx_data  = pdat;
            pend     = 0;
        end
        if (tx_load === 1'b1) begin
            k = load_cnt - base;
            if (tx_busy !== 1'b0) busy_viol++;
            load_cyc.push_back(cyc);
            load_dat.push_back(tx_data);
            if (k >= 0 && k < NB && cfg_dly[k] != 16'd0) begin
                pend = 1;
                due  = cyc + int'(cfg_dly[k]);
                pdat = tx_data ^ cfg_msk[k];
            end
            load_cnt++;
        end
    end

    // Reference model
    function automatic logic [7:0] exp_byte(input int k);
        logic [7:0] v;
        v = 8'hA5;
        for (int i = 0; i < k; i++) v = {v[6:0], ^(v & 8'hB8)};
        return v;
    endfunction

    function automatic bit accepted(input int d);
        return (d >= 1) && (d <= T);
    endfunction

    function automatic int eff(input int d);
        return accepted(d) ? d : T;
    endfunction

    task automatic model(input logic [3:0][15:0] dly, input logic [3:0][7:0] msk,
                         output int e, output int l);
        e = 0;
        l = 0;
        for (int k = 0; k < NB; k++) begin
            l++;
            if (!accepted(int'(dly[k])) || msk[k] != 8'h00) begin
                e++;
                if (STOP) break;
            end
        end
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_cfg(input string nm, input logic [3:0][15:0] dly,
                           input logic [3:0][7:0] msk, input int exp_err, input int exp_loads);
        int n, b, got, done_cyc;
        b       = load_cnt;
        base    = b;
        cfg_dly = dly;
        cfg_msk = msk;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(n);
        chk({nm, "/done"}, done, 1);
        done_cyc = cyc + 1;
        got = load_cnt - b;
        chk({nm, "/loads"}, got, exp_loads);
        chk({nm, "/err_count"}, err_count, exp_err);
        chk({nm, "/pass"}, pass, (exp_err == 0));
        chk({nm, "/faulty"}, m_i_faulty, (exp_err != 0));
        chk({nm, "/sel_busy"}, {sel, busy}, 0);
        for (int i = 0; i < got && i < exp_loads; i++)
            chk($sformatf("%s/tx_data%0d", nm, i), load_dat[b+i], exp_byte(i));
        for (int i = 0; i + 1 < got && i + 1 < exp_loads; i++)
            chk($sformatf("%s/gap%0d", nm, i), load_cyc[b+i+1] - load_cyc[b+i],
                eff(int'(dly[i])) + 2);
        if (got > 0 && got == exp_loads)
            chk({nm, "/done_lat"}, done_cyc - load_cyc[b+got-1], eff(int'(dly[got-1])) + 2);
    endtask

    typedef struct {
        string            name;
        logic [3:0][15:0] dly;
        logic [3:0][7:0]  msk;
        int               exp_err;
        int               exp_loads;
    } vec_t;

    function automatic vec_t mk(input string nm, input logic [3:0][15:0] d,
                                input logic [3:0][7:0] m, input int e, input int l);
        vec_t v;
        v.name = nm; v.dly = d; v.msk = m; v.exp_err = e; v.exp_loads = l;
        return v;
    endfunction

    vec_t       vecs[6];
    logic [7:0] golden[4];

    initial begin
        int n, b, c0, e, l;
        logic [3:0][15:0] rd;
        logic [3:0][7:0]  rm;

        vecs[0] = mk("clean",    {16'd100, 16'd100, 16'd100, 16'd100}, '0, 0, 4);
        vecs[1] = mk("bad2nd",   {16'd100, 16'd100, 16'd100, 16'd100},
                     {8'h00, 8'h00, 8'h01, 8'h00}, 1, STOP ? 2 : 4);
        vecs[2] = mk("silent",   '0, '0, STOP ? 1 : 4, STOP ? 1 : 4);
        vecs[3] = mk("coincide", {16'(T), 16'(T), 16'(T), 16'(T)}, '0, 0, 4);
        vecs[4] = mk("late",     {16'd7, 16'd7, 16'd7, 16'(T + 1)}, '0, 1, STOP ? 1 : 4);
        vecs[5] = mk("quick",    {16'd1, 16'd1, 16'd1, 16'd1},
                     {8'h80, 8'h00, 8'h00, 8'h00}, 1, 4);
        golden[0] = 8'hA5; golden[1] = 8'h4A; golden[2] = 8'h95; golden[3] = 8'h2A;

        rst = 1'b0; start = 1'b0; abort = 1'b0; tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset/outputs", {tx_data, tx_load, sel, busy, done, pass, m_i_faulty, err_count}, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle/outputs", {tx_data, tx_load, sel, busy, done, pass, m_i_faulty, err_count}, 0);

        for (int i = 0; i < 6; i++)
            run_cfg(vecs[i].name, vecs[i].dly, vecs[i].msk, vecs[i].exp_err, vecs[i].exp_loads);
        for (int i = 0; i < 4; i++)
            chk($sformatf("clean/golden%0d", i),
                (i < load_dat.size()) ? load_dat[i] : 8'hxx, golden[i]);

        // Transmitter busy for 30 cycles after LOAD entry
        b = load_cnt; base = b;
        cfg_dly = {16'd20, 16'd20, 16'd20, 16'd20}; cfg_msk = '0;
        c0 = cyc;
        start = 1'b1; tx_busy = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (31) @(negedge clk);
        chk("busy/no_early_load", load_cnt - b, 0);
        tx_busy = 1'b0;
        wait_done(n);
        chk("busy/done", done, 1);
        chk("busy/first_load_cyc", (load_cnt > b) ? load_cyc[b] : -1, c0 + 33);
        chk("busy/loads", load_cnt - b, 4);
        chk("busy/pass", pass, 1);

        // Abort while waiting on the third byte
        b = load_cnt; base = b;
        cfg_dly = {16'd0, 16'd0, 16'd30, 16'd30};
        cfg_msk = STOP ? '0 : {8'h00, 8'h00, 8'h10, 8'h00};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (load_cnt - b < 3 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("abort/reached_byte3", load_cnt - b, 3);
        repeat (5) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort/ctrl", {sel, busy, done, tx_load, pass, m_i_faulty}, 0);
        chk("abort/err_retained", err_count, STOP ? 0 : 1);
        repeat (3) @(negedge clk);
        chk("abort/no_more_loads", load_cnt - b, 3);
        run_cfg("rerun", {16'd50, 16'd50, 16'd50, 16'd50}, '0, 0, 4);

        // Randomized runs against the model
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < NB; k++) begin
                case ($urandom_range(0, 9))
                    0: rd[k] = 16'd0;
                    1: rd[k] = 16'(T);
                    2: rd[k] = 16'(T + 1);
                    default: rd[k] = 16'($urandom_range(1, T - 1));
                endcase
                rm[k] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            end
            model(rd, rm, e, l);
            run_cfg($sformatf("rand%0d", r), rd, rm, e, l);
        end

        // Asynchronous reset in the middle of a run
        b = load_cnt; base = b;
        cfg_dly = '0; cfg_msk = '0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #3 rst = 1'b0;
        #1;
        chk("rst_mid/outputs", {tx_data, tx_load, sel, busy, done, pass, m_i_faulty, err_count}, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("rst_mid/loads", load_cnt - b, 1);
        chk("rst_mid/idle", {tx_data, tx_load, sel, busy, done, pass, m_i_faulty, err_count}, 0);

        chk("load_while_busy", busy_viol, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
